// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared VRAM types, default sizes and arbiter state encoding
package vram_arbiter_pkg;

    localparam int NUM_CORES   = 4;
    localparam int VRAM_ADDR_W = 19;
    localparam int VRAM_DATA_W = 8;

    typedef logic [VRAM_ADDR_W-1:0]       vram_addr_t;
    typedef logic [VRAM_DATA_W-1:0]       vram_word_t;
    typedef logic [$clog2(NUM_CORES)-1:0] core_id_t;

    typedef enum logic {
        s_idle = 1'b0,
        s_busy = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder starting at ptr
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    localparam logic [W:0] NV = (W+1)'(N);

    logic [W:0] sum;

    // Walk offsets from farthest to nearest so the nearest active core to ptr wins
    always_comb begin
        any = |req;
        idx = '0;
        sum = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (W+1)'(i);
            sum = (sum >= NV) ? sum - NV : sum;
            if (req[sum[W-1:0]]) idx = sum[W-1:0];
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: round-robin sharing of one VRAM port among NUM_CORES core datapaths
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int NUM_CORES = vram_arbiter_pkg::NUM_CORES,
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int DATA_W    = VRAM_DATA_W,
    parameter int IW        = $clog2(NUM_CORES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CORES-1:0]             req_active,
    input  logic [NUM_CORES-1:0]             req_w,
    input  logic [NUM_CORES-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES-1:0][DATA_W-1:0] req_in,
    output logic [NUM_CORES-1:0]             req_ready,
    output logic [DATA_W-1:0]                req_out,
    output logic                             mem_active,
    output logic                             mem_w,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_in,
    input  logic                             mem_ready,
    input  logic [DATA_W-1:0]                mem_out,
    output logic [IW-1:0]                    grant_id,
    output logic                             busy
);

    localparam logic [IW-1:0] LAST = IW'(NUM_CORES - 1);

    arb_state_t    state, state_n;
    logic [IW-1:0] rr_ptr, rr_ptr_n, grant_n, pick_idx;
    logic          pick_any;

    rr_pick #(.N(NUM_CORES), .W(IW)) u_pick (
        .req (req_active),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // State, round-robin pointer and grant register; reset abandons any open transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= s_idle;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            grant_id <= grant_n;
        end
    end

    // Grant in idle, hold until memory completes, then advance the pointer past the winner
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        grant_n  = grant_id;
        if (state == s_idle) begin
            state_n = pick_any ? s_busy : s_idle;
            grant_n = pick_any ? pick_idx : grant_id;
        end else if (mem_ready) begin
            state_n  = s_idle;
            rr_ptr_n = (grant_id == LAST) ? '0 : grant_id + 1'b1;
        end
    end

    // Memory side follows the granted core; completion is routed back the same cycle
    always_comb begin
        busy       = (state == s_busy);
        mem_active = busy;
        mem_w      = req_w[grant_id];
        mem_addr   = req_addr[grant_id];
        mem_in     = req_in[grant_id];
        req_ready  = (busy && mem_ready) ? (NUM_CORES'(1) << grant_id) : '0;
        req_out    = mem_out;
    end

endmodule
